// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// FSM state encoding, line format constants and baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // Rounded clock cycles per bit
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream carrying received UART bytes.
// master drives valid/data, slave returns ready.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo_show_ahead.sv
// Single-clock FIFO with combinational show-ahead read of the head entry.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo_show_ahead #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO.
// Mid-bit sampling from a fixed clock/baud divisor; bytes leave on a valid/ready stream.
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rxd,
    uart_rx_fifo_if.master              stream,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        overflow
);
    import uart_pkg::*;

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic                 s1;
    logic                 rxs;
    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [2:0]           idx;
    logic [2:0]           idx_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 push_req;
    logic                 push_n;
    logic                 tick;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 ok;
`ifdef UART_RX_PARITY_EN
    logic                 par;
    logic                 par_n;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= rxd;
            rxs <= s1;
        end
    end

    assign tick = (cnt == '0);

`ifdef UART_RX_PARITY_EN
    assign ok = ~(^shreg ^ par);
`else
    assign ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shreg    <= shreg_n;
            push_req <= push_n;
`ifdef UART_RX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        push_n    = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n      = par;
        parity_err = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = HALF;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rxs) begin
                    state_n = DATA;
                    cnt_n   = FULL;
                    idx_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shreg_n[idx] = rxs;
                    cnt_n        = FULL;
                    idx_n        = idx + 1'b1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_n   = rxs;
                    cnt_n   = FULL;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rxs) begin
                    state_n = IDLE;
                    push_n  = ok;
`ifdef UART_RX_PARITY_EN
                    parity_err = !ok;
`endif
                end else begin
                    // Bad stop wins over parity; line stays latched until it idles
                    frame_err = 1'b1;
                    state_n   = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pop              = stream.out_valid && stream.out_ready;
    assign stream.out_valid = !empty;
    assign overflow         = push_req && full && !pop;

    sync_fifo_show_ahead #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (stream.out_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default divisor (217 clocks/bit).
// Table-driven single frames plus hand-written multi-frame sequences.
module tb_uart_rx_fifo;

    localparam int DIV = 217;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         hold;
        int         exp_pops;
        logic [7:0] exp_byte;
        int         exp_fe;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd   = 1'b1;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_fifo_if sif ();

    uart_rx_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .rxd        (rxd),
        .stream     (sif),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int cyc     = 0;
    int n_chk   = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int hi_cnt  = 0;
    int t_rise  = -1;
    int t_start = 0;
    logic v_prev = 1'b0;
    logic [7:0] got[$];
    vec_t vecs[7];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (sif.out_valid) hi_cnt++;
        if (sif.out_valid && !v_prev && t_rise < 0) t_rise = cyc;
        v_prev = sif.out_valid;
        if (sif.out_valid && sif.out_ready) got.push_back(sif.out_data);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic level(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop, input int hold);
        t_start = cyc;
        level(1'b0, DIV);
        for (int i = 0; i < 8; i++) level(d[i], DIV);
        if (stop) begin
            level(1'b1, DIV);
        end else begin
            level(1'b0, hold);
            level(1'b1, DIV);
        end
    endtask

    task automatic drain(input int n);
        sif.out_ready = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        sif.out_ready = 1'b0;
    endtask

    function automatic int got_at(input int i);
        if (i < got.size()) return int'(got[i]);
        return -1;
    endfunction

    initial begin
        int n0;
        int fe0;
        int ov0;
        int hi0;
        int lat;

        sif.out_ready = 1'b0;
        vecs[0] = '{8'h55, 1'b1, 0,    1, 8'h55, 0};
        vecs[1] = '{8'h00, 1'b1, 0,    1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 0,    1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 2000, 0, 8'h00, 1};
        vecs[4] = '{8'h12, 1'b1, 0,    1, 8'h12, 0};
        vecs[5] = '{8'h80, 1'b1, 0,    1, 8'h80, 0};
        vecs[6] = '{8'h01, 1'b1, 0,    1, 8'h01, 0};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_valid", int'(sif.out_valid), 0);
        check("rst_data", int'(sif.out_data), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overflow", int'(overflow), 0);
        level(1'b1, 20);

        // Single byte latency and one-cycle valid with consumer ready
        sif.out_ready = 1'b1;
        t_rise = -1;
        hi0 = hi_cnt;
        n0  = got.size();
        fe0 = fe_cnt;
        send(8'h55, 1'b1, 0);
        level(1'b1, 300);
        lat = t_rise - t_start;
        check("lat_window", int'(lat >= 9 * DIV && lat <= 10 * DIV + 8), 1);
        check("lat_valid_cycles", hi_cnt - hi0, 1);
        check("lat_pops", got.size() - n0, 1);
        check("lat_data", got_at(n0), 8'h55);
        check("lat_frame_err", fe_cnt - fe0, 0);

        for (int v = 0; v < 7; v++) begin
            n0  = got.size();
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send(vecs[v].data, vecs[v].stop, vecs[v].hold);
            level(1'b1, 300);
            check($sformatf("vec%0d_pops", v), got.size() - n0, vecs[v].exp_pops);
            if (vecs[v].exp_pops > 0)
                check($sformatf("vec%0d_data", v), got_at(n0), int'(vecs[v].exp_byte));
            check($sformatf("vec%0d_frame_err", v), fe_cnt - fe0, vecs[v].exp_fe);
            check($sformatf("vec%0d_overflow", v), ov_cnt - ov0, 0);
            check($sformatf("vec%0d_count", v), int'(fifo_count), 0);
        end
        sif.out_ready = 1'b0;

        // Back-to-back frames buffered while consumer stalls
        n0  = got.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send(8'hA3, 1'b1, 0);
        send(8'h00, 1'b1, 0);
        send(8'hFF, 1'b1, 0);
        level(1'b1, 300);
        check("b2b_count", int'(fifo_count), 3);
        check("b2b_stalled", got.size() - n0, 0);
        drain(10);
        check("b2b_pops", got.size() - n0, 3);
        check("b2b_d0", got_at(n0), 8'hA3);
        check("b2b_d1", got_at(n0 + 1), 8'h00);
        check("b2b_d2", got_at(n0 + 2), 8'hFF);
        check("b2b_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("b2b_count_after", int'(fifo_count), 0);

        // Short low glitch rejected at the start-bit midpoint
        n0  = got.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        level(1'b0, 50);
        level(1'b1, 400);
        check("glitch_count", int'(fifo_count), 0);
        check("glitch_valid", int'(sif.out_valid), 0);
        check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // 17 bytes into a 16-deep FIFO: last one dropped
        n0  = got.size();
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b1, 0);
        level(1'b1, 300);
        check("ovf_count", int'(fifo_count), 16);
        check("ovf_pulses", ov_cnt - ov0, 1);
        check("ovf_frame_err", fe_cnt - fe0, 0);
        drain(25);
        check("ovf_pops", got.size() - n0, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_d%0d", i), got_at(n0 + i), i);
        check("ovf_count_after", int'(fifo_count), 0);

        // Reset during bit 4 of 0x81 flushes FIFO and drops partial byte
        n0  = got.size();
        fe0 = fe_cnt;
        send(8'h5A, 1'b1, 0);
        level(1'b1, 300);
        check("rmf_pre_count", int'(fifo_count), 1);
        level(1'b0, DIV);
        level(1'b1, DIV);
        level(1'b0, DIV);
        level(1'b0, DIV);
        level(1'b0, DIV);
        level(1'b0, DIV / 2);
        reset = 1'b1;
        rxd   = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rmf_flush_count", int'(fifo_count), 0);
        check("rmf_flush_valid", int'(sif.out_valid), 0);
        level(1'b1, 500);
        send(8'h7E, 1'b1, 0);
        level(1'b1, 300);
        check("rmf_count", int'(fifo_count), 1);
        drain(5);
        check("rmf_pops", got.size() - n0, 1);
        check("rmf_data", got_at(n0), 8'h7E);
        check("rmf_frame_err", fe_cnt - fe0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
